add_seq_64b: RTL and testbench
==============================

# add_seq_64b

Multi-cycle 64-bit add/subtract sequencer that time-multiplexes a single instance of the team's 16-bit carry-lookahead adder (cla_16b) over four passes, chaining the carry through a register between passes. Sits between an operand producer and a result consumer with valid/ready handshakes on both sides. It trades three extra cycles of latency for one-quarter of the adder area of a flat 64-bit CLA, and is the wide-arithmetic unit for the datapath.

## Interface
- N, 16, slice width; must equal the cla_16b width
- WORDS, 4, slices per operand; operand width W = N*WORDS = 64
- clk  in  1  rising-edge clock
- rst_n  in  1  synchronous, active-low reset; sampled on rising clk
- in_valid  in  1  operand request
- in_ready  out  1  high only in IDLE
- a  in  W  operand A
- b  in  W  operand B
- sub  in  1  0: A+B+c_in; 1: A-B (c_in ignored)
- c_in  in  1  carry-in for add
- out_valid  out  1  result available
- out_ready  in  1  consumer accepts result
- sum  out  W  result
- c_out  out  1  final carry; for sub, 1 = no borrow (A >= B unsigned)
- ovfl  out  1  two's-complement overflow
- zero  out  1  sum == 0

## Operation
- States: IDLE, RUN, DONE (2-bit encoding).
- IDLE: in_ready=1. On in_valid&&in_ready: latch a into op_a, latch (sub ? ~b : b) into op_b, carry <= (sub ? 1 : c_in), slice index k <= 0, store sign bits a[W-1] and (sub ? ~b[W-1] : b[W-1]), go RUN.
- RUN: cla_16b inputs are op_a[k*N +: N], op_b[k*N +: N], and carry. Each cycle: sum[k*N +: N] <= CLA sum, carry <= CLA c_out, k <= k+1. When k == WORDS-1, go DONE.
- Entering DONE: c_out <= final carry; ovfl <= (stored sign A == stored sign B') && (sum[W-1] != stored sign A); zero <= (full sum == 0), evaluated on the completed value that includes the last slice.
- DONE: out_valid=1. sum, c_out, ovfl and zero stay stable until out_valid&&out_ready, then go IDLE. in_ready stays 0, so there is no accept-and-complete in the same cycle.
- in_valid is ignored outside IDLE. Operands must not change the in-flight op.
- Arithmetic is modulo 2^W. Bits above W are discarded.
- Reset values: state=IDLE, in_ready=1 after reset (0 while rst_n low), out_valid=0, sum=0, c_out=0, ovfl=0, zero=0, carry=0, k=0.
- Reset asserted mid-RUN or in DONE: the op is dropped and all state returns to reset values on that edge. No partial result is exposed.

## Timing
- Accept edge T0 → slices 0..3 written at T0+1..T0+4 → out_valid high from T0+4 edge onward. Latency is 4 cycles.
- Result held indefinitely under out_ready=0.
- Handshake at edge Td → IDLE at Td; next accept no earlier than Td+1. Minimum issue interval is 6 cycles with out_ready held high.
- Critical path: carry reg → cla_16b → sum/carry regs. No path from a/b to outputs.

## Structure
- Shared package/header add_seq_pkg holds: state encodings (IDLE, RUN, DONE), N, WORDS, and the derived W and index width clog2(WORDS).
- One sub-module: the existing cla_16b, instantiated once. The sequencer adds only the FSM, operand/result registers and the slice mux/demux.

## Test plan
- Add: a=64'h0000_0000_FFFF_FFFF, b=1, sub=0, c_in=0 → sum=64'h0000_0001_0000_0000, c_out=0, ovfl=0, zero=0; out_valid rises exactly 4 cycles after accept.
- Full ripple: a=64'hFFFF_FFFF_FFFF_FFFF, b=0, c_in=1 → sum=0, c_out=1, zero=1, ovfl=0.
- Subtract: a=5, b=7, sub=1 → sum=64'hFFFF_FFFF_FFFF_FFFE, c_out=0. Then a=7, b=5 → sum=2, c_out=1.
- Overflow: a=64'h7FFF_FFFF_FFFF_FFFF, b=1, add → ovfl=1, sum=64'h8000_0000_0000_0000. Also a=64'h8000_0000_0000_0000, b=1, sub=1 → ovfl=1.
- Backpressure and ignore: hold out_ready=0 for 10 cycles in DONE with in_valid=1 and new operands → result stable, in_ready=0, no new accept. Release → IDLE next edge, then accept.
- Reset mid-op: drop rst_n for one cycle at RUN k=2 → all outputs return to reset values on that edge, out_valid never asserts for the dropped op, and the next op completes correctly.

Source files
------------

// File: rtl/add_seq_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : add_seq_pkg
//  Description : Shared constants and FSM state encoding for the multi-cycle
//                64-bit add/subtract sequencer.
//  Revision    : 1.0 - initial release
// ============================================================================
package add_seq_pkg;

   // Slice width (must match cla_16b) and number of slices per operand.
   localparam int N     = 16;
   localparam int WORDS = 4;
   localparam int W     = N * WORDS;
   localparam int KW    = $clog2(WORDS);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

endpackage
`default_nettype wire

// File: rtl/cla_16b.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : cla_16b
//  Description : 16-bit two-level carry-lookahead adder built from four 4-bit
//                groups. Group generate/propagate terms feed a lookahead
//                carry chain; bit carries are resolved inside each group.
//  Revision    : 1.0 - initial release
// ============================================================================
module cla_16b (
   input  logic [15:0] a,
   input  logic [15:0] b,
   input  logic        c_in,
   output logic [15:0] sum,
   output logic        c_out
);

   localparam int GROUPS = 4;

   logic [15:0]       p;
   logic [15:0]       g;
   logic [15:0]       c;
   logic [GROUPS-1:0] grp_p;
   logic [GROUPS-1:0] grp_g;
   logic              grp_c;
   logic              bit_c;

   assign p = a ^ b;
   assign g = a & b;

   // Group generate / propagate for each 4-bit block
   generate
      for (genvar j = 0; j < GROUPS; j++) begin : g_grp
         assign grp_p[j] = &p[4*j +: 4];
         assign grp_g[j] = g[4*j+3]
                         | (p[4*j+3] & g[4*j+2])
                         | (p[4*j+3] & p[4*j+2] & g[4*j+1])
                         | (p[4*j+3] & p[4*j+2] & p[4*j+1] & g[4*j]);
      end
   endgenerate

   // Group-level lookahead carries, then per-bit carries within each group
   always_comb begin
      c     = '0;
      grp_c = c_in;
      bit_c = 1'b0;
      for (int j = 0; j < GROUPS; j++) begin
         bit_c = grp_c;
         for (int i = 0; i < 4; i++) begin
            c[4*j+i] = bit_c;
            bit_c    = g[4*j+i] | (p[4*j+i] & bit_c);
         end
         grp_c = grp_g[j] | (grp_p[j] & grp_c);
      end
      sum   = p ^ c;
      c_out = grp_c;
   end

endmodule
`default_nettype wire

// File: rtl/add_seq_64b.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : add_seq_64b
//  Description : Multi-cycle 64-bit add/subtract sequencer. One cla_16b is
//                time-multiplexed over four slices with the carry chained
//                through a register. Valid/ready handshakes on both sides.
//  Revision    : 1.0 - initial release
// ============================================================================
module add_seq_64b
   import add_seq_pkg::*;
(
   input  logic         clk,
   input  logic         rst_n,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [W-1:0] a,
   input  logic [W-1:0] b,
   input  logic         sub,
   input  logic         c_in,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [W-1:0] sum,
   output logic         c_out,
   output logic         ovfl,
   output logic         zero
);

   localparam logic [KW-1:0] LAST_K = KW'(WORDS - 1);

   state_t        state;
   state_t        state_next;
   logic [W-1:0]  op_a;
   logic [W-1:0]  op_b;
   logic [W-1:0]  sum_next;
   logic          carry;
   logic          sign_a;
   logic          sign_b;
   logic [KW-1:0] k;
   logic [N-1:0]  slice_a;
   logic [N-1:0]  slice_b;
   logic [N-1:0]  slice_sum;
   logic          slice_cout;
   logic          accept;
   logic          last;

   // State register
   always_ff @(posedge clk) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_next;
   end

   // Next-state logic and handshake outputs
   always_comb begin
      state_next = state;
      in_ready   = 1'b0;
      out_valid  = 1'b0;
      accept     = 1'b0;
      last       = 1'b0;
      case (state)
         IDLE: begin
            in_ready = rst_n;
            accept   = in_valid & rst_n;
            if (accept) state_next = RUN;
         end
         RUN: begin
            last = (k == LAST_K);
            if (last) state_next = DONE;
         end
         DONE: begin
            out_valid = 1'b1;
            if (out_ready) state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

   // Slice select into the adder and write-back of the current slice
   always_comb begin
      slice_a             = op_a[k*N +: N];
      slice_b             = op_b[k*N +: N];
      sum_next            = sum;
      sum_next[k*N +: N]  = slice_sum;
   end

   cla_16b u_cla (
      .a     (slice_a),
      .b     (slice_b),
      .c_in  (carry),
      .sum   (slice_sum),
      .c_out (slice_cout)
   );

   // Operand capture, per-slice accumulation and final flag evaluation
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         op_a   <= '0;
         op_b   <= '0;
         carry  <= 1'b0;
         sign_a <= 1'b0;
         sign_b <= 1'b0;
         k      <= '0;
         sum    <= '0;
         c_out  <= 1'b0;
         ovfl   <= 1'b0;
         zero   <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (accept) begin
                  // Subtraction is A + ~B + 1, so invert B and force the carry.
                  op_a   <= a;
                  op_b   <= sub ? ~b : b;
                  carry  <= sub ? 1'b1 : c_in;
                  sign_a <= a[W-1];
                  sign_b <= sub ? ~b[W-1] : b[W-1];
                  k      <= '0;
               end
            end
            RUN: begin
               sum   <= sum_next;
               carry <= slice_cout;
               k     <= k + 1'b1;
               if (last) begin
                  // Flags use the completed value including the final slice.
                  c_out <= slice_cout;
                  ovfl  <= (sign_a == sign_b) && (sum_next[W-1] != sign_a);
                  zero  <= (sum_next == '0);
               end
            end
            default: ;
         endcase
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_add_seq_64b.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : tb_add_seq_64b
//  Description : Self-checking bench for add_seq_64b with an arithmetic
//                reference model and scenario tasks.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_add_seq_64b;

   localparam int W = 64;

   typedef struct packed {
      logic [W-1:0] sum;
      logic         c_out;
      logic         ovfl;
      logic         zero;
   } res_t;

   typedef struct packed {
      logic [W-1:0] x;
      logic [W-1:0] y;
      logic         s;
      logic         ci;
      res_t         exp;
   } vec_t;

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic         in_valid = 1'b0;
   logic         in_ready;
   logic [W-1:0] a = '0;
   logic [W-1:0] b = '0;
   logic         sub = 1'b0;
   logic         c_in = 1'b0;
   logic         out_valid;
   logic         out_ready = 1'b0;
   logic [W-1:0] sum;
   logic         c_out;
   logic         ovfl;
   logic         zero;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   add_seq_64b dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .a         (a),
      .b         (b),
      .sub       (sub),
      .c_in      (c_in),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .sum       (sum),
      .c_out     (c_out),
      .ovfl      (ovfl),
      .zero      (zero)
   );

   // Reference: plain modular arithmetic plus exact signed range check
   function automatic res_t model(input logic [W-1:0] x, input logic [W-1:0] y,
                                  input logic s, input logic ci);
      res_t                 r;
      logic [W:0]           wide;
      logic signed [W+1:0]  sx;
      logic signed [W+1:0]  sy;
      logic signed [W+1:0]  sc;
      logic signed [W+1:0]  exact;
      logic signed [W+1:0]  got;
      sx = $signed({{2{x[W-1]}}, x});
      sy = $signed({{2{y[W-1]}}, y});
      sc = $signed({{(W+1){1'b0}}, ci});
      if (s) begin
         r.sum   = x - y;
         r.c_out = (x >= y);
         exact   = sx - sy;
      end else begin
         wide    = {1'b0, x} + {1'b0, y} + {{W{1'b0}}, ci};
         r.sum   = wide[W-1:0];
         r.c_out = wide[W];
         exact   = sx + sy + sc;
      end
      got    = $signed({{2{r.sum[W-1]}}, r.sum});
      r.ovfl = (exact != got);
      r.zero = (r.sum == '0);
      return r;
   endfunction

   function automatic logic [W-1:0] rnd_op();
      logic [W-1:0] v;
      case ($urandom_range(0, 5))
         0:       v = '0;
         1:       v = '1;
         2:       v = 64'h8000_0000_0000_0000;
         3:       v = 64'h7FFF_FFFF_FFFF_FFFF;
         default: v = {$urandom, $urandom};
      endcase
      return v;
   endfunction

   // Present one operand set and let it be accepted on the next edge.
   task automatic start_op(input logic [W-1:0] x, input logic [W-1:0] y,
                           input logic s, input logic ci, output bit ok);
      int n = 0;
      while (!in_ready && n < 20) begin
         @(posedge clk); #1;
         n++;
      end
      ok       = in_ready;
      a        = x;
      b        = y;
      sub      = s;
      c_in     = ci;
      in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
   endtask

   task automatic wait_valid(output int lat);
      lat = 0;
      while (!out_valid && lat < 20) begin
         @(posedge clk); #1;
         lat++;
      end
   endtask

   task automatic finish_op();
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
   endtask

   task automatic test_reset();
      res_t got;
      rst_n = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      got = {sum, c_out, ovfl, zero};
      checks++;
      if (in_ready !== 1'b0 || out_valid !== 1'b0) begin
         errors++;
         $display("FAIL reset_hs: in_ready=%b out_valid=%b required 0 0", in_ready, out_valid);
      end
      checks++;
      if (got !== '0) begin
         errors++;
         $display("FAIL reset_out: got %h required 0", got);
      end
      rst_n = 1'b1;
      @(posedge clk); #1;
      checks++;
      if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
         errors++;
         $display("FAIL reset_release: in_ready=%b out_valid=%b required 1 0", in_ready, out_valid);
      end
   endtask

   task automatic test_directed();
      vec_t tbl[8];
      res_t got;
      int   lat;
      bit   ok;
      tbl[0] = {64'h0000_0000_FFFF_FFFF, 64'h1, 1'b0, 1'b0, {64'h0000_0001_0000_0000, 1'b0, 1'b0, 1'b0}};
      tbl[1] = {64'hFFFF_FFFF_FFFF_FFFF, 64'h0, 1'b0, 1'b1, {64'h0, 1'b1, 1'b0, 1'b1}};
      tbl[2] = {64'h5, 64'h7, 1'b1, 1'b0, {64'hFFFF_FFFF_FFFF_FFFE, 1'b0, 1'b0, 1'b0}};
      tbl[3] = {64'h7, 64'h5, 1'b1, 1'b0, {64'h2, 1'b1, 1'b0, 1'b0}};
      tbl[4] = {64'h7FFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, 1'b0, {64'h8000_0000_0000_0000, 1'b0, 1'b1, 1'b0}};
      tbl[5] = {64'h8000_0000_0000_0000, 64'h1, 1'b1, 1'b0, {64'h7FFF_FFFF_FFFF_FFFF, 1'b1, 1'b1, 1'b0}};
      tbl[6] = {64'h5, 64'h5, 1'b1, 1'b0, {64'h0, 1'b1, 1'b0, 1'b1}};
      tbl[7] = {64'h7, 64'h5, 1'b1, 1'b1, {64'h2, 1'b1, 1'b0, 1'b0}};
      for (int i = 0; i < 8; i++) begin
         start_op(tbl[i].x, tbl[i].y, tbl[i].s, tbl[i].ci, ok);
         wait_valid(lat);
         checks++;
         if (!ok || lat != 4 || out_valid !== 1'b1) begin
            errors++;
            $display("FAIL dir_latency[%0d]: accepted=%b latency=%0d required 4", i, ok, lat);
         end
         got = {sum, c_out, ovfl, zero};
         checks++;
         if (got !== tbl[i].exp) begin
            errors++;
            $display("FAIL dir_result[%0d]: got sum=%h c=%b v=%b z=%b required sum=%h c=%b v=%b z=%b",
                     i, got.sum, got.c_out, got.ovfl, got.zero,
                     tbl[i].exp.sum, tbl[i].exp.c_out, tbl[i].exp.ovfl, tbl[i].exp.zero);
         end
         finish_op();
         checks++;
         if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL dir_idle[%0d]: in_ready=%b out_valid=%b required 1 0", i, in_ready, out_valid);
         end
      end
   endtask

   task automatic test_random();
      logic [W-1:0] x;
      logic [W-1:0] y;
      logic         s;
      logic         ci;
      res_t         exp;
      res_t         got;
      int           lat;
      bit           ok;
      for (int i = 0; i < 40; i++) begin
         x   = rnd_op();
         y   = rnd_op();
         s   = 1'($urandom_range(0, 1));
         ci  = 1'($urandom_range(0, 1));
         exp = model(x, y, s, ci);
         start_op(x, y, s, ci, ok);
         wait_valid(lat);
         got = {sum, c_out, ovfl, zero};
         checks++;
         if (!ok || lat != 4 || got !== exp) begin
            errors++;
            $display("FAIL rand[%0d]: a=%h b=%h sub=%b cin=%b lat=%0d got %h/%b%b%b required %h/%b%b%b (lat 4)",
                     i, x, y, s, ci, lat, got.sum, got.c_out, got.ovfl, got.zero,
                     exp.sum, exp.c_out, exp.ovfl, exp.zero);
         end
         finish_op();
      end
   endtask

   task automatic test_backpressure();
      logic [W-1:0] x;
      logic [W-1:0] y;
      res_t         exp;
      res_t         got;
      int           lat;
      bit           ok;
      x   = {$urandom, $urandom};
      y   = {$urandom, $urandom};
      exp = model(x, y, 1'b0, 1'b1);
      start_op(x, y, 1'b0, 1'b1, ok);
      wait_valid(lat);
      for (int i = 0; i < 10; i++) begin
         a        = {$urandom, $urandom};
         b        = {$urandom, $urandom};
         sub      = 1'($urandom_range(0, 1));
         in_valid = 1'b1;
         @(posedge clk); #1;
         got = {sum, c_out, ovfl, zero};
         checks++;
         if (!ok || out_valid !== 1'b1 || in_ready !== 1'b0 || got !== exp) begin
            errors++;
            $display("FAIL bp_hold[%0d]: out_valid=%b in_ready=%b got %h required %h with valid=1 ready=0",
                     i, out_valid, in_ready, got, exp);
         end
      end
      x         = {$urandom, $urandom};
      y         = {$urandom, $urandom};
      a         = x;
      b         = y;
      sub       = 1'b1;
      exp       = model(x, y, 1'b1, 1'b0);
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
      checks++;
      if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
         errors++;
         $display("FAIL bp_release: in_ready=%b out_valid=%b required 1 0", in_ready, out_valid);
      end
      @(posedge clk); #1;
      in_valid = 1'b0;
      checks++;
      if (in_ready !== 1'b0) begin
         errors++;
         $display("FAIL bp_accept: in_ready=%b required 0", in_ready);
      end
      wait_valid(lat);
      got = {sum, c_out, ovfl, zero};
      checks++;
      if (lat != 4 || got !== exp) begin
         errors++;
         $display("FAIL bp_next: lat=%0d got %h required %h (lat 4)", lat, got, exp);
      end
      finish_op();
   endtask

   task automatic test_reset_mid_op();
      logic [W-1:0] x;
      logic [W-1:0] y;
      res_t         exp;
      res_t         got;
      int           lat;
      bit           ok;
      bit           seen;
      start_op(64'h1234_5678_9ABC_DEF0, 64'h0FED_CBA9_8765_4321, 1'b0, 1'b0, ok);
      repeat (2) begin
         @(posedge clk); #1;
      end
      rst_n = 1'b0;
      @(posedge clk); #1;
      got = {sum, c_out, ovfl, zero};
      checks++;
      if (!ok || got !== '0 || out_valid !== 1'b0 || in_ready !== 1'b0) begin
         errors++;
         $display("FAIL rst_mid: got %h out_valid=%b in_ready=%b required 0 0 0", got, out_valid, in_ready);
      end
      rst_n = 1'b1;
      seen  = 1'b0;
      for (int i = 0; i < 8; i++) begin
         @(posedge clk); #1;
         if (out_valid) seen = 1'b1;
      end
      checks++;
      if (seen || in_ready !== 1'b1) begin
         errors++;
         $display("FAIL rst_dropped: out_valid seen=%b in_ready=%b required 0 1", seen, in_ready);
      end
      x   = {$urandom, $urandom};
      y   = {$urandom, $urandom};
      exp = model(x, y, 1'b1, 1'b0);
      start_op(x, y, 1'b1, 1'b0, ok);
      wait_valid(lat);
      got = {sum, c_out, ovfl, zero};
      checks++;
      if (!ok || lat != 4 || got !== exp) begin
         errors++;
         $display("FAIL rst_next: lat=%0d got %h required %h (lat 4)", lat, got, exp);
      end
      finish_op();
   endtask

   task automatic test_back_to_back();
      res_t q[$];
      res_t got;
      res_t exp;
      int   issued = 0;
      int   done = 0;
      int   cyc = 0;
      int   last_acc = -1;
      bit   acc;
      bit   hs;
      a         = rnd_op();
      b         = rnd_op();
      sub       = 1'($urandom_range(0, 1));
      c_in      = 1'($urandom_range(0, 1));
      in_valid  = 1'b1;
      out_ready = 1'b1;
      while (done < 5 && cyc < 100) begin
         acc = in_ready && in_valid;
         hs  = out_valid;
         if (hs) begin
            got = {sum, c_out, ovfl, zero};
            checks++;
            if (q.size() == 0) begin
               errors++;
               $display("FAIL b2b_spurious: result %h with no op outstanding", got);
            end else begin
               exp = q.pop_front();
               if (got !== exp) begin
                  errors++;
                  $display("FAIL b2b_result[%0d]: got %h required %h", done, got, exp);
               end
            end
            done++;
         end
         @(posedge clk); #1;
         cyc++;
         if (acc) begin
            q.push_back(model(a, b, sub, c_in));
            if (last_acc >= 0) begin
               checks++;
               if (cyc - last_acc != 6) begin
                  errors++;
                  $display("FAIL b2b_interval: got %0d cycles required 6", cyc - last_acc);
               end
            end
            last_acc = cyc;
            issued++;
            if (issued < 5) begin
               a    = rnd_op();
               b    = rnd_op();
               sub  = 1'($urandom_range(0, 1));
               c_in = 1'($urandom_range(0, 1));
            end else begin
               in_valid = 1'b0;
            end
         end
      end
      checks++;
      if (done != 5) begin
         errors++;
         $display("FAIL b2b_count: completed %0d required 5", done);
      end
      in_valid  = 1'b0;
      out_ready = 1'b0;
   endtask

   initial begin
      test_reset();
      test_directed();
      test_random();
      test_backpressure();
      test_reset_mid_op();
      test_back_to_back();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
`default_nettype wire
